pwm_peripheral: RTL and testbench
=================================

Name: pwm_peripheral

Overview:
Consumes the five configuration registers written over SPI by the SPI register block and drives the 16 user outputs.
- Each output bit is forced low, forced high, or driven by one shared PWM waveform, selected per bit by its enable bits.
- The PWM is an 8-bit counter advanced by a clock prescaler.
- The duty cycle is double-buffered so the waveform never glitches mid-period.
- Sits directly downstream of the SPI register block, in the same clk domain, with no CDC.

Parameters:
- CLK_DIV, 13, clk cycles per PWM counter step (legal range ≥1). Period = CLK_DIV*256 clk cycles, about 3.0 kHz at 10 MHz.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enable, bits 7:0
- en_reg_out_15_8  input  8  output enable, bits 15:8
- en_reg_pwm_7_0  input  8  PWM-mode select, bits 7:0
- en_reg_pwm_15_8  input  8  PWM-mode select, bits 15:8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out  output  16  registered user outputs
- period_start  output  1  one-cycle strobe, asserted in the cycle the PWM counter wraps to 0

Behaviour:
- Reset is asynchronous on rst_n low. While reset is asserted:
  - prescaler, pwm_cnt and duty_shadow are 0;
  - out is 16'h0000 and period_start is 0.
- Reset mid-period aborts the period. After reset release the count restarts from 0 with duty_shadow = 0, so all PWM-mode outputs stay low until the first period boundary.
- Prescaler:
  - counts 0..CLK_DIV-1 and wraps;
  - tick = (prescaler == CLK_DIV-1);
  - with CLK_DIV = 1, tick is asserted every cycle.
- pwm_cnt: 8 bits, increments on tick, wraps 255 -> 0 naturally with no saturation.
- Boundary event = tick && pwm_cnt == 255. On this edge:
  - pwm_cnt becomes 0;
  - duty_shadow <= pwm_duty_cycle;
  - period_start is registered high for exactly the following cycle.
- Duty writes that arrive mid-period are not applied until the next boundary. If several writes arrive within one period, the last value present at the boundary wins.
- pwm_level (combinational from current state):
  - 1 if duty_shadow == 8'hFF (true 100%);
  - otherwise (pwm_cnt < duty_shadow).
  - Result: duty 0x00 gives constant 0; duty N gives N*CLK_DIV high cycles per period, for 1 ≤ N ≤ 254.
- Per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - out[i] <= !en_out[i] ? 0 : (en_pwm[i] ? pwm_level : 1).
  - en_pwm is ignored when en_out is 0.
- Latency:
  - enable or mode changes appear on out exactly 1 clk after the input changes;
  - out reflects the pwm_cnt/duty_shadow state of the previous cycle;
  - duty changes appear at the first period after the next boundary.
- All PWM-mode bits share one waveform and are phase-aligned, with no per-channel skew.
- Inputs are already synchronous to clk; the block adds no synchronisers.

Decomposition:
- Package pwm_pkg:
  - NUM_CH = 16, DUTY_W = 8, CNT_MAX = 8'hFF, DUTY_FULL = 8'hFF;
  - default CLK_DIV = 13.
- One sub-module, pwm_timebase (param CLK_DIV):
  - contains the prescaler and pwm_cnt;
  - outputs pwm_cnt[7:0] and the boundary strobe.
- The top level holds duty_shadow, the pwm_level compare, the output mux/register and the period_start register.

Test Plan:
- Reset: hold rst_n=0 with all inputs 0xFF -> out == 0 and period_start == 0. Release rst_n -> PWM bits stay 0 for the first 3328 cycles (CLK_DIV=13), then go high.
- Static modes: en_out=0xFFFF, en_pwm=0x0000 -> out == 0xFFFF one clk later. Then en_out=0x00F0 -> out == 0x00F0 one clk later. Then en_out=0, en_pwm=0xFFFF -> out == 0.
- Duty 50%: CLK_DIV=2, en_out=en_pwm=0x0001, duty=0x80, measured after the first boundary -> out[0] high for exactly 256 cycles and low for 256, period 512, rising edge 1 clk after period_start.
- Extremes: duty=0x00 -> out[0] constant 0 over 3 periods. duty=0xFF -> out[0] constant 1, no low cycle. duty=0x01 with CLK_DIV=2 -> exactly 2 high cycles per 512.
- Glitch-free update: change duty 0x40 -> 0xC0 at cnt = 100 -> current period keeps 0x40 timing (64*CLK_DIV high cycles); the next period shows 0xC0 timing; period_start width is 1 cycle throughout.
- Mid-operation reset: assert rst_n at cnt = 200 with duty 0xFF -> out drops to 0 asynchronously (before the next clk edge). After release the counter restarts at 0 and duty_shadow == 0 until the first boundary.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output peripheral.
package pwm_pkg;

  localparam int unsigned NUM_CH          = 16;
  localparam int unsigned DUTY_W          = 8;
  localparam int unsigned CLK_DIV_DEFAULT = 13;

  localparam logic [DUTY_W-1:0] CNT_MAX   = 8'hFF;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/pwm_peripheral_timebase.sv
// Prescaler plus 8-bit PWM counter; flags the edge on which the counter wraps.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              boundary
);

  // Keep at least one prescaler bit so CLK_DIV = 1 still elaborates.
  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0]  prescaler_q, prescaler_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              tick;

  always_comb begin
    tick        = (prescaler_q == PRE_W'(CLK_DIV - 1));
    prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
    boundary    = tick && (pwm_cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 user outputs low, high or from one shared PWM waveform whose duty
// cycle is double-buffered and only taken up on period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [DUTY_W-1:0] pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic [DUTY_W-1:0] pwm_cnt;
  logic              boundary;

  logic [DUTY_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              period_start_q, period_start_d;
  logic [NUM_CH-1:0] en_out, en_pwm;
  logic              pwm_level;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_cnt  (pwm_cnt),
    .boundary (boundary)
  );

  always_comb begin
    en_out         = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm         = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    // 0xFF is a true 100%, not 255/256.
    pwm_level      = (duty_shadow_q == DUTY_FULL) || (pwm_cnt < duty_shadow_q);
    out_d          = en_out & (~en_pwm | {NUM_CH{pwm_level}});
    duty_shadow_d  = boundary ? pwm_duty_cycle : duty_shadow_q;
    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Two instances (CLK_DIV 13 and 2) share stimulus and are compared every cycle
// against an arithmetic model derived from elapsed cycles since reset release.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo = 8'hFF, eo_hi = 8'hFF, ep_lo = 8'hFF, ep_hi = 8'hFF;
  logic [7:0]  duty = 8'hFF;
  logic [15:0] out13, out2;
  logic        ps13, ps2;

  int checks = 0;
  int failures = 0;

  int          dv[2] = '{13, 2};
  int          k[2]  = '{0, 0};
  int          sh[2] = '{0, 0};
  int          hi[2] = '{0, 0};
  int          psn[2] = '{0, 0};
  logic [15:0] o[2];
  logic        ps[2];

  always #5 clk = ~clk;

  pwm_peripheral u_dut13 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out13),
    .period_start    (ps13)
  );

  pwm_peripheral #(.CLK_DIV(2)) u_dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out2),
    .period_start    (ps2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the pre-edge model state, advance the model, compare.
  task automatic step();
    logic [15:0] eo, ep;
    logic [15:0] exp_o[2];
    logic        exp_ps[2];
    logic        lvl;
    eo = {eo_hi, eo_lo};
    ep = {ep_hi, ep_lo};
    for (int d = 0; d < 2; d++) begin
      exp_ps[d] = 1'b0;
      if (!rst_n) exp_o[d] = 16'h0000;
      else begin
        lvl = (sh[d] == 255) || (((k[d] / dv[d]) % 256) < sh[d]);
        exp_o[d] = eo & (~ep | {16{lvl}});
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        k[d]  = 0;
        sh[d] = 0;
      end else begin
        k[d]++;
        exp_ps[d] = ((k[d] % (256 * dv[d])) == 0);
        if (exp_ps[d]) sh[d] = int'(duty);
      end
    end
    #1;
    o[0] = out13; o[1] = out2;
    ps[0] = ps13; ps[1] = ps2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("out_div%0d", dv[d]), 32'(o[d]), 32'(exp_o[d]));
      check($sformatf("period_start_div%0d", dv[d]), 32'(ps[d]), 32'(exp_ps[d]));
      hi[d]  += int'(o[d][0]);
      psn[d] += int'(ps[d]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_meas();
    hi  = '{0, 0};
    psn = '{0, 0};
  endtask

  task automatic wait_ps(input int d, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      seen = ps[d];
    end
    check("wait_period_start", 32'(seen), 32'd1);
  endtask

  initial begin
    // Reset held with every input at 0xFF.
    run(4);
    check("rst_out13", 32'(out13), 32'h0);
    check("rst_out2", 32'(out2), 32'h0);
    check("rst_ps13", 32'(ps13), 32'h0);

    // First period after release runs with duty_shadow 0.
    @(negedge clk);
    rst_n = 1'b1;
    clr_meas();
    run(3328);
    check("first_period_hi_div13", 32'(hi[0]), 32'd0);
    step();
    check("after_first_boundary_div13", 32'(out13), 32'hFFFF);

    // Static modes.
    {eo_hi, eo_lo} = 16'hFFFF; {ep_hi, ep_lo} = 16'h0000;
    step();
    check("static_all_high", 32'(out13), 32'hFFFF);
    {eo_hi, eo_lo} = 16'h00F0;
    step();
    check("static_f0", 32'(out13), 32'h00F0);
    {eo_hi, eo_lo} = 16'h0000; {ep_hi, ep_lo} = 16'hFFFF;
    step();
    check("static_pwm_ignored", 32'(out13), 32'h0000);

    // Randomized enables and duty.
    for (int seg = 0; seg < 16; seg++) begin
      eo_lo = 8'($urandom); eo_hi = 8'($urandom);
      ep_lo = 8'($urandom); ep_hi = 8'($urandom);
      duty  = 8'($urandom);
      if (seg % 4 == 0) duty = (seg % 8 == 0) ? 8'h00 : 8'hFF;
      run(int'($urandom_range(50, 600)));
    end

    // 50% on the CLK_DIV=2 instance.
    {eo_hi, eo_lo} = 16'h0001; {ep_hi, ep_lo} = 16'h0001;
    duty = 8'h80;
    wait_ps(1, 600);
    clr_meas();
    step();
    check("rise_after_period_start", 32'(out2[0]), 32'd1);
    run(511);
    check("duty80_high", 32'(hi[1]), 32'd256);
    check("duty80_ps_count", 32'(psn[1]), 32'd1);

    // Extremes.
    duty = 8'h00;
    wait_ps(1, 600);
    clr_meas();
    run(3 * 512);
    check("duty00_high", 32'(hi[1]), 32'd0);
    duty = 8'hFF;
    wait_ps(1, 600);
    clr_meas();
    run(512);
    check("dutyFF_high", 32'(hi[1]), 32'd512);
    duty = 8'h01;
    wait_ps(1, 600);
    clr_meas();
    run(512);
    check("duty01_high", 32'(hi[1]), 32'd2);

    // Mid-period duty change is deferred to the next period.
    duty = 8'h40;
    wait_ps(1, 600);
    clr_meas();
    run(200);
    duty = 8'hC0;
    run(312);
    check("glitch_cur_high", 32'(hi[1]), 32'd128);
    check("glitch_cur_ps", 32'(psn[1]), 32'd1);
    clr_meas();
    run(512);
    check("glitch_next_high", 32'(hi[1]), 32'd384);
    check("glitch_next_ps", 32'(psn[1]), 32'd1);

    // Reset at cnt 200 with duty 0xFF.
    {eo_hi, eo_lo} = 16'hFFFF; {ep_hi, ep_lo} = 16'hFFFF;
    duty = 8'hFF;
    wait_ps(1, 600);
    run(400);
    check("pre_reset_out2", 32'(out2), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check("async_rst_out2", 32'(out2), 32'h0);
    check("async_rst_out13", 32'(out13), 32'h0);
    run(3);
    @(negedge clk);
    rst_n = 1'b1;
    clr_meas();
    run(512);
    check("post_rst_shadow0_div2", 32'(hi[1]), 32'd0);
    step();
    check("post_rst_boundary_div2", 32'(out2), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
